// File: rtl/ledbcm.sv
// ledbcm: dual-half 12-bit framebuffer feeding HUB75 RGB bits via frame-level binary-coded modulation.
// Optional LEDBCM_DOUBLEBUF_EN adds front/back banks exchanged at BCM cycle end on a pending swap.
module ledbcm #(
  parameter int BPC = 4,
  parameter int ADDRX_W = 7,
  parameter int ADDRY_W = 5,
  localparam int PW = BPC > 1 ? $clog2(BPC) : 1,
  localparam int RW = BPC > 1 ? BPC - 1 : 1,
  localparam int AW = ADDRY_W + ADDRX_W,
  localparam int DW = 3 * BPC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ADDRX_W-1:0] addrx,
  input  logic [ADDRY_W-1:0] addry,
  input  logic            latch,
  input  logic            blank,
  input  logic            wr_en,
  input  logic [AW:0]     wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            swap,
  output logic [2:0]      rgb0,
  output logic [2:0]      rgb1,
  output logic            latch_o,
  output logic            blank_o,
  output logic [PW-1:0]   plane,
  output logic            cycle_end
);
`ifdef LEDBCM_DOUBLEBUF_EN
  localparam int MW = AW + 1;
  logic front, pending;
  logic [MW-1:0] raddr, waddr;
  assign raddr = {front, addry, addrx};
  assign waddr = {~front, wr_addr[AW-1:0]};
  // a swap seen in the cycle_end cycle itself is kept for the next cycle end
  always_ff @(posedge clk)
    if (reset) begin
      front <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (cycle_end && pending) front <= ~front;
      pending <= swap | (pending & ~cycle_end);
    end
`else
  localparam int MW = AW;
  logic unused_swap;
  logic [MW-1:0] raddr, waddr;
  assign unused_swap = swap;
  assign raddr = {addry, addrx};
  assign waddr = wr_addr[AW-1:0];
`endif
  logic [DW-1:0] mem_u [2**MW];
  logic [DW-1:0] mem_l [2**MW];
  logic [DW-1:0] rd_u, rd_l;
  logic [PW-1:0] pl_d;
  logic [2:0] sel_u, sel_l;
  logic [1:0] lat_d, blk_d;
  logic [RW-1:0] rep;
  logic fe, last, top;
  always_ff @(posedge clk)
    if (wr_en) begin
      if (wr_addr[AW]) mem_l[waddr] <= wr_data;
      else mem_u[waddr] <= wr_data;
    end
  // plane travels with the read data so in-flight pixels keep the plane they were read under
  always_comb begin
    sel_u = '0;
    sel_l = '0;
    for (int c = 0; c < 3; c++) begin
      sel_u[c] = rd_u[c*BPC + 32'(pl_d)];
      sel_l[c] = rd_l[c*BPC + 32'(pl_d)];
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      rd_u <= '0;
      rd_l <= '0;
      pl_d <= '0;
      rgb0 <= '0;
      rgb1 <= '0;
      lat_d <= 2'b00;
      blk_d <= 2'b11;
    end else begin
      rd_u <= mem_u[raddr];
      rd_l <= mem_l[raddr];
      pl_d <= plane;
      rgb0 <= sel_u;
      rgb1 <= sel_l;
      lat_d <= {lat_d[0], latch};
      blk_d <= {blk_d[0], blank};
    end
  assign latch_o = lat_d[1];
  assign blank_o = blk_d[1];
  assign fe = latch && &addry;
  assign last = rep == RW'((32'd1 << plane) - 32'd1);
  assign top = plane == PW'(BPC - 1);
  always_ff @(posedge clk)
    if (reset) begin
      plane <= '0;
      rep <= '0;
      cycle_end <= 1'b0;
    end else begin
      cycle_end <= fe && last && top;
      if (fe) begin
        rep <= last ? '0 : rep + 1'b1;
        if (last) plane <= top ? '0 : plane + 1'b1;
      end
    end
endmodule
